// File: rtl/ml_peak_detect.sv
// ML timing metric peak detector: forms L(k) = |gamma(k)| - Phi(k) per accepted sample and
// reports the argmax (index, metric, gamma re/im) once per SYM_LEN-sample window.
module ml_peak_detect #(
  parameter int unsigned PHI_W   = 15,
  parameter int unsigned SYM_LEN = 80,
  parameter int unsigned IDX_W   = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic signed [PHI_W-1:0] gamma_mag,
  input  logic signed [PHI_W-1:0] gamma_re,
  input  logic signed [PHI_W-1:0] gamma_im,
  input  logic signed [PHI_W-1:0] phi_in,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        theta_out,
  output logic signed [PHI_W:0]   peak_metric,
  output logic signed [PHI_W-1:0] peak_re,
  output logic signed [PHI_W-1:0] peak_im
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SYM_LEN - 1);

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // S1: metric formation
  logic                    v_s1_q, v_s1_d;
  logic                    first_s1_q, first_s1_d;
  logic                    last_s1_q, last_s1_d;
  logic [IDX_W-1:0]        idx_s1_q, idx_s1_d;
  logic signed [PHI_W:0]   metric_s1_q, metric_s1_d;
  logic signed [PHI_W-1:0] re_s1_q, re_s1_d;
  logic signed [PHI_W-1:0] im_s1_q, im_s1_d;

  // S2: running best of the current window
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic signed [PHI_W:0]   best_metric_q, best_metric_d;
  logic signed [PHI_W-1:0] best_re_q, best_re_d;
  logic signed [PHI_W-1:0] best_im_q, best_im_d;

  // Output registers
  logic                    out_valid_q, out_valid_d;
  logic [IDX_W-1:0]        theta_q, theta_d;
  logic signed [PHI_W:0]   metric_q, metric_d;
  logic signed [PHI_W-1:0] re_q, re_d;
  logic signed [PHI_W-1:0] im_q, im_d;

  logic                    accept, abort, s2_fire, take;
  logic [IDX_W-1:0]        win_idx;
  logic signed [PHI_W:0]   win_metric;
  logic signed [PHI_W-1:0] win_re, win_im;

  // Control: FSM next state, sample acceptance and window counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // en low in SEARCH drops the partial window, including a sample offered that cycle
    accept  = (state_q == StSearch) && en && in_valid;
    abort   = (state_q == StSearch) && !en;

    unique case (state_q)
      StIdle:   if (en) state_d = StSearch;
      StSearch: if (!en) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (state_q != StSearch || !en) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
    end
  end

  // Pipeline datapath: S1 capture, S2 compare, output load
  always_comb begin
    v_s1_d      = accept;
    first_s1_d  = first_s1_q;
    last_s1_d   = last_s1_q;
    idx_s1_d    = idx_s1_q;
    metric_s1_d = metric_s1_q;
    re_s1_d     = re_s1_q;
    im_s1_d     = im_s1_q;
    if (accept) begin
      first_s1_d  = (cnt_q == '0);
      last_s1_d   = (cnt_q == LastIdx);
      idx_s1_d    = cnt_q;
      // One extra bit makes the difference exact for any pair of inputs
      metric_s1_d = $signed({gamma_mag[PHI_W-1], gamma_mag}) - $signed({phi_in[PHI_W-1], phi_in});
      re_s1_d     = gamma_re;
      im_s1_d     = gamma_im;
    end

    s2_fire = v_s1_q && !abort;
    // Strict compare keeps the earliest index on ties; first_s1 restarts the search
    take    = first_s1_q || (metric_s1_q > best_metric_q);

    win_idx    = take ? idx_s1_q    : best_idx_q;
    win_metric = take ? metric_s1_q : best_metric_q;
    win_re     = take ? re_s1_q     : best_re_q;
    win_im     = take ? im_s1_q     : best_im_q;

    best_idx_d    = best_idx_q;
    best_metric_d = best_metric_q;
    best_re_d     = best_re_q;
    best_im_d     = best_im_q;
    if (s2_fire && take) begin
      best_idx_d    = idx_s1_q;
      best_metric_d = metric_s1_q;
      best_re_d     = re_s1_q;
      best_im_d     = im_s1_q;
    end

    out_valid_d = s2_fire && last_s1_q;
    theta_d     = theta_q;
    metric_d    = metric_q;
    re_d        = re_q;
    im_d        = im_q;
    if (out_valid_d) begin
      theta_d  = win_idx;
      metric_d = win_metric;
      re_d     = win_re;
      im_d     = win_im;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      v_s1_q        <= 1'b0;
      first_s1_q    <= 1'b0;
      last_s1_q     <= 1'b0;
      idx_s1_q      <= '0;
      metric_s1_q   <= '0;
      re_s1_q       <= '0;
      im_s1_q       <= '0;
      best_idx_q    <= '0;
      best_metric_q <= '0;
      best_re_q     <= '0;
      best_im_q     <= '0;
      out_valid_q   <= 1'b0;
      theta_q       <= '0;
      metric_q      <= '0;
      re_q          <= '0;
      im_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      v_s1_q        <= v_s1_d;
      first_s1_q    <= first_s1_d;
      last_s1_q     <= last_s1_d;
      idx_s1_q      <= idx_s1_d;
      metric_s1_q   <= metric_s1_d;
      re_s1_q       <= re_s1_d;
      im_s1_q       <= im_s1_d;
      best_idx_q    <= best_idx_d;
      best_metric_q <= best_metric_d;
      best_re_q     <= best_re_d;
      best_im_q     <= best_im_d;
      out_valid_q   <= out_valid_d;
      theta_q       <= theta_d;
      metric_q      <= metric_d;
      re_q          <= re_d;
      im_q          <= im_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign theta_out   = theta_q;
  assign peak_metric = metric_q;
  assign peak_re     = re_q;
  assign peak_im     = im_q;

endmodule

// File: tb/tb_ml_peak_detect.sv
// Bench for ml_peak_detect: table of windows, scoreboard of expected pulses, corner sequences.
module tb_ml_peak_detect;
  localparam int PHI_W   = 15;
  localparam int SYM_LEN = 80;
  localparam int IDX_W   = 7;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    en = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [PHI_W-1:0] gamma_mag = '0;
  logic signed [PHI_W-1:0] gamma_re = '0;
  logic signed [PHI_W-1:0] gamma_im = '0;
  logic signed [PHI_W-1:0] phi_in = '0;
  logic                    out_valid;
  logic [IDX_W-1:0]        theta_out;
  logic signed [PHI_W:0]   peak_metric;
  logic signed [PHI_W-1:0] peak_re;
  logic signed [PHI_W-1:0] peak_im;

  ml_peak_detect #(.PHI_W(PHI_W), .SYM_LEN(SYM_LEN), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .gamma_mag  (gamma_mag),
    .gamma_re   (gamma_re),
    .gamma_im   (gamma_im),
    .phi_in     (phi_in),
    .out_valid  (out_valid),
    .theta_out  (theta_out),
    .peak_metric(peak_metric),
    .peak_re    (peak_re),
    .peak_im    (peak_im)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [PHI_W-1:0] base_mag, base_phi;
    logic signed [PHI_W-1:0] pk_mag, pk_phi, pk_re, pk_im;
    int                      pk_idx, tie_idx;
    logic [IDX_W-1:0]        exp_theta;
    logic signed [PHI_W:0]   exp_metric;
  } win_t;

  typedef struct {
    int                      exp_cyc;
    logic [IDX_W-1:0]        theta;
    logic signed [PHI_W:0]   metric;
    logic signed [PHI_W-1:0] re, im;
  } exp_t;

  win_t tbl[7];
  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic win_t mk(input logic signed [PHI_W-1:0] bm, bp, pm, pp, pr, pi,
                              input int idx, tie, input logic signed [PHI_W:0] em);
    win_t w;
    w.base_mag = bm; w.base_phi = bp; w.pk_mag = pm; w.pk_phi = pp;
    w.pk_re = pr; w.pk_im = pi; w.pk_idx = idx; w.tie_idx = tie;
    w.exp_theta = IDX_W'(idx); w.exp_metric = em;
    return w;
  endfunction

  // Scoreboard: each expected result must appear exactly on its cycle
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("pulse_on_time", out_valid, 1);
      if (out_valid) begin
        check("theta_out", theta_out, e.theta);
        check("peak_metric", peak_metric, e.metric);
        check("peak_re", peak_re, e.re);
        check("peak_im", peak_im, e.im);
      end
    end else if (out_valid) begin
      check("unexpected_pulse", out_valid, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    in_valid  = 1'b0;
    gamma_mag = PHI_W'($urandom);
    gamma_re  = PHI_W'($urandom);
    gamma_im  = PHI_W'($urandom);
    phi_in    = PHI_W'($urandom);
    tick();
  endtask

  task automatic drive_sample(input win_t w, input int i, input bit push);
    in_valid = 1'b1;
    if (i == w.pk_idx) begin
      gamma_mag = w.pk_mag; phi_in = w.pk_phi; gamma_re = w.pk_re; gamma_im = w.pk_im;
    end else if (i == w.tie_idx) begin
      gamma_mag = w.pk_mag; phi_in = w.pk_phi; gamma_re = ~w.pk_re; gamma_im = ~w.pk_im;
    end else begin
      gamma_mag = w.base_mag; phi_in = w.base_phi;
      gamma_re = PHI_W'($urandom); gamma_im = PHI_W'($urandom);
    end
    if (push && i == SYM_LEN - 1) begin
      exp_t e;
      e.exp_cyc = cyc + 2;
      e.theta = w.exp_theta; e.metric = w.exp_metric; e.re = w.pk_re; e.im = w.pk_im;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic run_window(input win_t w, input bit gaps, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) gap();
      drive_sample(w, i, push);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_theta"}, theta_out, 0);
    check({tag, "_metric"}, peak_metric, 0);
    check({tag, "_re"}, peak_re, 0);
    check({tag, "_im"}, peak_im, 0);
  endtask

  initial begin
    tbl[0] = mk(15'sh0080, 15'sh0100, 15'sh0500, 15'sh0100, 15'sh0300, -15'sh0100, 37, -1,
                16'sh0400);
    tbl[1] = mk(15'sh0000, 15'sh0200, 15'sh01F0, 15'sh0200, 15'sh0123, -15'sh0045, 10, 50,
                -16'sh0010);
    tbl[2] = mk(15'sh0100, 15'sh0100, 15'sh0300, 15'sh0080, 15'sh0011, 15'sh0022, 5, -1,
                16'sh0280);
    tbl[3] = mk(15'sh0100, 15'sh0100, 15'sh0300, 15'sh0080, -15'sh0033, 15'sh0044, 79, -1,
                16'sh0280);
    tbl[4] = mk(15'sh0100, 15'sh0100, 15'sh0300, 15'sh0080, 15'sh0055, -15'sh0066, 0, -1,
                16'sh0280);
    tbl[5] = mk(15'sh0100, 15'sh0100, 15'sh0200, -15'sh0100, 15'sh0777, 15'sh0888, 12, -1,
                16'sh0300);
    tbl[6] = mk(15'sh0000, 15'sh0000, 15'sh3FFF, -15'sh4000, -15'sh3FFF, 15'sh1234, 63, -1,
                16'sh7FFF);

    // Reset and idle
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      tick();
      check("idle_no_pulse", out_valid, 0);
    end
    in_valid = 1'b0;

    // Continuous windows, then gapped back-to-back windows
    en = 1'b1;
    tick();
    run_window(tbl[0], 1'b0, SYM_LEN, 1'b1);
    run_window(tbl[1], 1'b0, SYM_LEN, 1'b1);
    for (int k = 2; k <= 4; k++) run_window(tbl[k], 1'b1, SYM_LEN, 1'b1);
    repeat (4) tick();

    // Abort after 40 samples, resume with a fresh window
    run_window(tbl[3], 1'b0, 40, 1'b0);
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    tick();
    run_window(tbl[5], 1'b0, SYM_LEN, 1'b1);
    repeat (4) tick();

    // Reset mid-window
    run_window(tbl[0], 1'b0, 60, 1'b0);
    rst = 1'b0;
    tick();
    check_zero("midreset");
    rst = 1'b1;
    tick();
    run_window(tbl[6], 1'b0, SYM_LEN, 1'b1);
    repeat (5) tick();

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ml_peak_detect.md
Name: ml_peak_detect

Overview:
- Downstream of the sliding-window energy stage in the CP-correlation timing chain.
- Forms the ML timing metric Λ(k) = |γ(k)| − Φ(k) for each sample, then tracks the argmax over each symbol window of SYM_LEN samples.
- Once per window, emits the peak index θ, the peak metric, and the γ components at the peak, for the downstream angle/CFO stage.
- |γ(k)|, Φ(k) and γ re/im arrive time-aligned from upstream.

Parameters:
- PHI_W, 15, width of signed Q6.8 Φ, |γ| and γ re/im inputs.
- SYM_LEN, 80, samples per search window (N + L = 64 + 16).
- IDX_W, 7, width of sample index; must satisfy 2^IDX_W ≥ SYM_LEN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (reset when rst==0).
- en  in  1  search enable; low forces IDLE and discards any partial window.
- in_valid  in  1  input sample strobe; inputs sampled only when high.
- gamma_mag  in  PHI_W  |γ(k)|, Q6.8, signed type, value ≥ 0.
- gamma_re  in  PHI_W  Re γ(k), Q6.8 signed.
- gamma_im  in  PHI_W  Im γ(k), Q6.8 signed.
- phi_in  in  PHI_W  Φ(k), Q6.8 signed.
- out_valid  out  1  one-cycle pulse: window result valid.
- theta_out  out  IDX_W  index (0..SYM_LEN−1) of peak within window.
- peak_metric  out  PHI_W+1  Λ at peak, Q7.8 signed.
- peak_re  out  PHI_W  gamma_re at peak.
- peak_im  out  PHI_W  gamma_im at peak.

Behaviour:
- Reset (rst==0 at edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Counter, best registers and pipeline valids clear.
  - Reset mid-window discards the window; no out_valid is produced for it.
- FSM states IDLE, SEARCH:
  - IDLE→SEARCH when en==1. The first sample accepted in SEARCH is index 0.
  - SEARCH→IDLE when en==0. The partial window is dropped, the S1/S2 valids clear that cycle, and no result is produced.
  - SEARCH stays in SEARCH across windows; the counter wraps SYM_LEN−1→0 with no gap cycle.
- Counter cnt: advances only on accepted samples (in_valid && state==SEARCH). Gaps in in_valid stall the window; they do not advance it.
- Stage S1 (registered, on each accepted sample):
  - metric_s1 = sign-extended gamma_mag − sign-extended phi_in, PHI_W+1 bits, exact (no saturation).
  - Also captured: idx_s1 = cnt, re/im, first_s1 = (cnt==0), last_s1 = (cnt==SYM_LEN−1), v_s1 = 1.
  - Otherwise v_s1 = 0.
- Stage S2 (compare, when v_s1):
  - take = first_s1 || (metric_s1 > best_metric), signed strict compare.
  - Ties keep the earlier index.
  - If take, load best_metric, best_idx, best_re, best_im from S1.
- Output:
  - When v_s1 && last_s1, the output regs load the winner of this cycle (the S1 candidate if take, else the best registers), and out_valid = 1 for exactly one cycle.
  - Outputs hold their value between pulses; out_valid is 0 otherwise.
- Latency:
  - Last sample accepted at edge t; out_valid is high in the cycle after edge t+1 (2-cycle latency).
  - Back-to-back windows are legal: the new window's index 0 in S2 coincides with the previous output load, and first_s1 overrides best.
- Simultaneous events:
  - en falling in the same cycle a last sample is offered: the sample is not accepted and no result is produced.
  - rst dominates en and in_valid.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then rst=1, en=0, in_valid toggling → all outputs 0, out_valid never asserts.
- Single peak:
  - Stimulus: en=1; 80 continuous samples with phi_in=0x0100 (1.0); gamma_mag=0x0080 everywhere except index 37 = 0x0500, gamma_re=0x0300, gamma_im=−0x0100.
  - Required: out_valid exactly 2 cycles after the last sample is accepted; theta_out=37, peak_metric=0x0400, peak_re=0x0300, peak_im=−0x0100.
- Tie and negative metric:
  - Stimulus: all Λ negative (gamma_mag=0, phi_in=0x0200), except indices 10 and 50 with Λ = −0x0010.
  - Required: theta_out=10, peak_metric=−0x0010 (sign-extended).
- Valid gaps and back-to-back windows:
  - Stimulus: in_valid random 50% duty, 3 windows, peak indices 5, 79, 0.
  - Required: three pulses with theta_out 5, 79, 0; no window boundary slip.
- Abort:
  - Stimulus: deassert en after 40 samples, reassert after 3 cycles, then a full window with peak at 12.
  - Required: no pulse for the aborted window; next pulse theta_out=12 with index counting restarted at 0.
- Reset mid-window: rst=0 at sample 60 for 1 cycle → no pulse, outputs 0; the following full window reports correctly.
